// File: rtl/imgmem_cell_writer.sv
// imgmem_cell_writer
// ------------------
// Write-side engine for the 640x480, 8-bit palette-index image memory.
// Each accepted command is rasterised into memory writes, one pixel per
// clock. A command either fills one Tetris board cell or clears the whole
// board rectangle. The block runs entirely in the VGA clock domain.
//
// Ports:
//   iVGA_CLK       in   1   sole clock, rising edge
//   iRST_n         in   1   asynchronous active-low reset
//   cmd_valid      in   1   command present
//   cmd_ready      out  1   engine can accept a command (IDLE)
//   cmd_clear      in   1   1 = clear board, 0 = fill one cell
//   cmd_col        in   4   cell column
//   cmd_row        in   5   cell row
//   cmd_index      in   8   palette index to write
//   addr_imgmem_w  out  19  write address, y*640+x
//   data_imgmem_w  out  8   write data
//   wren_imgmem    out  1   write strobe, one pixel per asserted cycle
//   oBUSY          out  1   high while writing and during the DONE cycle
//   oDONE          out  1   one-cycle pulse at command completion
//   oDROP          out  1   one-cycle pulse when an out-of-range cell is discarded
//
// Configuration macro: IMGMEM_WRITER_BORDER_EN
//   Defined: the outline pixels of a cell are written with BORDER_INDEX.
//   Undefined: every pixel uses the command index; BORDER_INDEX is unused.

module imgmem_cell_writer #(
  parameter int         CELL_SIZE    = 20,
  parameter int         ORIGIN_X     = 220,
  parameter int         ORIGIN_Y     = 40,
  parameter int         GRID_COLS    = 10,
  parameter int         GRID_ROWS    = 20,
  parameter logic [7:0] BORDER_INDEX = 8'd0
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_clear,
  input  logic [3:0]  cmd_col,
  input  logic [4:0]  cmd_row,
  input  logic [7:0]  cmd_index,
  output logic [18:0] addr_imgmem_w,
  output logic [7:0]  data_imgmem_w,
  output logic        wren_imgmem,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oDROP
);

  localparam int LINE_PIXELS = 640;
  localparam int BOARD_W     = GRID_COLS * CELL_SIZE;
  localparam int BOARD_H     = GRID_ROWS * CELL_SIZE;

  localparam logic [9:0]  CELL_LAST    = 10'(CELL_SIZE - 1);
  localparam logic [9:0]  BOARD_LAST_X = 10'(BOARD_W - 1);
  localparam logic [9:0]  BOARD_LAST_Y = 10'(BOARD_H - 1);

  // Address jump from the last pixel of one line to the first of the next.
  localparam logic [18:0] CELL_STEP  = 19'(LINE_PIXELS - CELL_SIZE + 1);
  localparam logic [18:0] CLEAR_STEP = 19'(LINE_PIXELS - BOARD_W + 1);
  localparam logic [18:0] CLEAR_BASE = 19'(ORIGIN_Y * LINE_PIXELS + ORIGIN_X);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t state, next_state;

  logic [9:0]  px, py;
  logic        clear_q;
  logic [7:0]  index_q;

  logic [9:0]  px_d, py_d;
  logic        clear_d;
  logic [7:0]  index_d;
  logic [18:0] addr_d;
  logic [7:0]  data_d;
  logic        wren_d, ready_d, busy_d, done_d, drop_d;

  logic        accept, cell_bad, line_end, last_pixel;
  logic [9:0]  last_x, last_y;
  logic [18:0] cell_base;

  // Command decode and raster bookkeeping shared by the FSM and datapath.
  // The cell base address uses constant multiplies evaluated only at
  // accept; the per-pixel path is pure increment.
  assign accept     = (state == IDLE) && cmd_ready && cmd_valid;
  assign cell_bad   = !cmd_clear &&
                      ((int'(cmd_col) >= GRID_COLS) || (int'(cmd_row) >= GRID_ROWS));
  assign cell_base  = 19'((ORIGIN_Y + int'(cmd_row) * CELL_SIZE) * LINE_PIXELS
                          + ORIGIN_X + int'(cmd_col) * CELL_SIZE);
  assign last_x     = clear_q ? BOARD_LAST_X : CELL_LAST;
  assign last_y     = clear_q ? BOARD_LAST_Y : CELL_LAST;
  assign line_end   = (px == last_x);
  assign last_pixel = line_end && (py == last_y);

`ifndef IMGMEM_WRITER_BORDER_EN
  logic [7:0] border_unused;
  assign border_unused = BORDER_INDEX;
`endif

  // State register.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A dropped command never leaves IDLE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept && !cell_bad) next_state = WRITE;
      WRITE:   if (last_pixel)          next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: computes the values every output register takes at the
  // next edge, so each output is a flop. Data for a pixel is chosen from
  // the counters that pixel will carry, which keeps border selection in
  // step with the address.
  always_comb begin
    px_d    = px;
    py_d    = py;
    clear_d = clear_q;
    index_d = index_q;
    addr_d  = addr_imgmem_w;
    data_d  = data_imgmem_w;
    wren_d  = 1'b0;
    drop_d  = 1'b0;
    ready_d = (next_state == IDLE);
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == DONE);

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (cell_bad) begin
            drop_d = 1'b1;
          end else begin
            clear_d = cmd_clear;
            index_d = cmd_index;
            px_d    = 10'd0;
            py_d    = 10'd0;
            addr_d  = cmd_clear ? CLEAR_BASE : cell_base;
            wren_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (!last_pixel) begin
          wren_d = 1'b1;
          if (line_end) begin
            px_d   = 10'd0;
            py_d   = py + 10'd1;
            addr_d = addr_imgmem_w + (clear_q ? CLEAR_STEP : CELL_STEP);
          end else begin
            px_d   = px + 10'd1;
            addr_d = addr_imgmem_w + 19'd1;
          end
        end
      end
      default: ;
    endcase

    if (wren_d) begin
`ifdef IMGMEM_WRITER_BORDER_EN
      if (!clear_d && ((px_d == 10'd0) || (px_d == CELL_LAST) ||
                       (py_d == 10'd0) || (py_d == CELL_LAST))) begin
        data_d = BORDER_INDEX;
      end else begin
        data_d = index_d;
      end
`else
      data_d = index_d;
`endif
    end
  end

  // Output and datapath registers. Reset abandons any command at once:
  // the strobe drops asynchronously and nothing resumes afterwards.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      px            <= 10'd0;
      py            <= 10'd0;
      clear_q       <= 1'b0;
      index_q       <= 8'd0;
      addr_imgmem_w <= 19'd0;
      data_imgmem_w <= 8'd0;
      wren_imgmem   <= 1'b0;
      cmd_ready     <= 1'b0;
      oBUSY         <= 1'b0;
      oDONE         <= 1'b0;
      oDROP         <= 1'b0;
    end else begin
      px            <= px_d;
      py            <= py_d;
      clear_q       <= clear_d;
      index_q       <= index_d;
      addr_imgmem_w <= addr_d;
      data_imgmem_w <= data_d;
      wren_imgmem   <= wren_d;
      cmd_ready     <= ready_d;
      oBUSY         <= busy_d;
      oDONE         <= done_d;
      oDROP         <= drop_d;
    end
  end

endmodule

// File: tb/tb_imgmem_cell_writer.sv
// tb_imgmem_cell_writer
// ---------------------
// Self-checking bench for imgmem_cell_writer with default geometry and
// BORDER_INDEX overridden to 8'hAA so outline pixels are distinguishable.
// A table of commands with hand-computed first/last addresses, write
// counts and completion cycles is replayed in a loop; hand-written
// sequences cover reset values, drop followed by a back-to-back accept,
// and reset in the middle of a cell. Builds with or without
// IMGMEM_WRITER_BORDER_EN.

module tb_imgmem_cell_writer;

  localparam logic [7:0] BORDER_VAL = 8'hAA;
  localparam int         LIMIT      = 90000;
`ifdef IMGMEM_WRITER_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [3:0]  cmd_col;
  logic [4:0]  cmd_row;
  logic [7:0]  cmd_index;
  logic [18:0] addr;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        done;
  logic        drop;

  imgmem_cell_writer #(.BORDER_INDEX(BORDER_VAL)) dut (
    .iVGA_CLK      (clk),
    .iRST_n        (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_clear     (cmd_clear),
    .cmd_col       (cmd_col),
    .cmd_row       (cmd_row),
    .cmd_index     (cmd_index),
    .addr_imgmem_w (addr),
    .data_imgmem_w (data),
    .wren_imgmem   (wren),
    .oBUSY         (busy),
    .oDONE         (done),
    .oDROP         (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit clear;
    int col;
    int row;
    int idx;
    bit hold;
    int exp_drop;
    int exp_writes;
    int exp_first;
    int exp_last;
    int exp_done;
    int exp_ready;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  // Results of the most recent apply_stimulus call.
  int r_ready_pre, r_writes, r_first, r_last, r_addr_err, r_data_err;
  int r_done_cnt, r_done_at, r_drop_cnt, r_busy_err, r_ready_at;
  int r_border_cnt, r_idx_cnt;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Issue one command at a falling edge and observe every following cycle
  // until cmd_ready returns. Addresses and data are predicted per pixel
  // from raster position: address = y*640 + x.
  task automatic apply_stimulus(input vec_t v);
    int w, x0, y0, k, ex;
    bit on_edge;
    logic [7:0] ed;
    r_writes = 0; r_first = -1; r_last = -1; r_addr_err = 0; r_data_err = 0;
    r_done_cnt = 0; r_done_at = 0; r_drop_cnt = 0; r_busy_err = 0; r_ready_at = 0;
    r_border_cnt = 0; r_idx_cnt = 0;
    w  = v.clear ? 200 : 20;
    x0 = v.clear ? 220 : 220 + v.col * 20;
    y0 = v.clear ? 40  : 40 + v.row * 20;
    k  = 0;
    @(negedge clk);
    r_ready_pre = int'(cmd_ready);
    cmd_valid = 1'b1;
    cmd_clear = v.clear;
    cmd_col   = 4'(v.col);
    cmd_row   = 5'(v.row);
    cmd_index = 8'(v.idx);
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clk);
      if (!v.hold) cmd_valid = 1'b0;
      if (wren) begin
        ex = (y0 + k / w) * 640 + x0 + (k % w);
        if (int'(addr) != ex) r_addr_err++;
        on_edge = !v.clear && ((k % w) == 0 || (k % w) == 19 || (k / w) == 0 || (k / w) == 19);
        ed = (BORDER_ON && on_edge) ? BORDER_VAL : 8'(v.idx);
        if (data !== ed) r_data_err++;
        if (data == BORDER_VAL) r_border_cnt++;
        if (data == 8'(v.idx)) r_idx_cnt++;
        if (k == 0) r_first = int'(addr);
        r_last = int'(addr);
        k++;
      end
      if (done) begin
        r_done_cnt++;
        r_done_at = c;
      end
      if (drop) r_drop_cnt++;
      if (busy !== (wren | done)) r_busy_err++;
      if (cmd_ready) begin
        r_ready_at = c;
        break;
      end
    end
    cmd_valid = 1'b0;
    r_writes = k;
  endtask

  initial begin
    int wcount, dcount;
    bit reached;

    vecs[0] = '{1'b0, 0,  0,  'h05, 1'b0, 0, 400,   25820,  37999,  401,   402};
    vecs[1] = '{1'b0, 9,  19, 'h03, 1'b0, 0, 400,   269200, 281379, 401,   402};
    vecs[2] = '{1'b0, 10, 0,  'h44, 1'b0, 1, 0,     -1,     -1,     0,     1};
    vecs[3] = '{1'b0, 4,  20, 'h44, 1'b0, 1, 0,     -1,     -1,     0,     1};
    vecs[4] = '{1'b0, 3,  7,  'h1C, 1'b1, 0, 400,   115480, 127659, 401,   402};
    vecs[5] = '{1'b0, 5,  10, 'h07, 1'b0, 0, 400,   153920, 166099, 401,   402};
    vecs[6] = '{1'b1, 15, 31, 'h0F, 1'b0, 0, 80000, 25820,  281379, 80001, 80002};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    cmd_col = 4'd0;
    cmd_row = 5'd0;
    cmd_index = 8'd0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_output("reset cmd_ready", int'(cmd_ready), 0);
    check_output("reset addr", int'(addr), 0);
    check_output("reset data", int'(data), 0);
    check_output("reset wren", int'(wren), 0);
    check_output("reset busy", int'(busy), 0);
    check_output("reset done", int'(done), 0);
    check_output("reset drop", int'(drop), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("post-reset cmd_ready", int'(cmd_ready), 1);

    // Table-driven commands.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("v%0d ready before accept", i), r_ready_pre, 1);
      check_output($sformatf("v%0d drop pulses", i), r_drop_cnt, vecs[i].exp_drop);
      check_output($sformatf("v%0d writes", i), r_writes, vecs[i].exp_writes);
      check_output($sformatf("v%0d first addr", i), r_first, vecs[i].exp_first);
      check_output($sformatf("v%0d last addr", i), r_last, vecs[i].exp_last);
      check_output($sformatf("v%0d addr sequence errors", i), r_addr_err, 0);
      check_output($sformatf("v%0d data errors", i), r_data_err, 0);
      check_output($sformatf("v%0d done pulses", i), r_done_cnt, vecs[i].exp_drop != 0 ? 0 : 1);
      check_output($sformatf("v%0d done cycle", i), r_done_at, vecs[i].exp_done);
      check_output($sformatf("v%0d busy errors", i), r_busy_err, 0);
      check_output($sformatf("v%0d ready cycle", i), r_ready_at, vecs[i].exp_ready);
      if (i == 5) begin
        check_output("v5 border pixel count", r_border_cnt, BORDER_ON ? 76 : 0);
        check_output("v5 index pixel count", r_idx_cnt, BORDER_ON ? 324 : 400);
      end
    end

    // Dropped command immediately followed by a valid one.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_clear = 1'b0;
    cmd_col = 4'd10;
    cmd_row = 5'd0;
    cmd_index = 8'h44;
    @(negedge clk);
    check_output("b2b drop pulse", int'(drop), 1);
    check_output("b2b ready after drop", int'(cmd_ready), 1);
    check_output("b2b no write on drop", int'(wren), 0);
    cmd_col = 4'd1;
    cmd_index = 8'h22;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("b2b second wren", int'(wren), 1);
    check_output("b2b second addr", int'(addr), 25840);
    check_output("b2b drop cleared", int'(drop), 0);
    wcount = 1;
    reached = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (wren) wcount++;
      if (cmd_ready) begin
        reached = 1'b1;
        break;
      end
    end
    check_output("b2b completed", int'(reached), 1);
    check_output("b2b writes", wcount, 400);

    // Reset during the 200th write of a cell.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_clear = 1'b0;
    cmd_col = 4'd2;
    cmd_row = 5'd1;
    cmd_index = 8'h11;
    wcount = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (wren) wcount++;
      if (wcount == 200) break;
    end
    check_output("midreset writes before reset", wcount, 200);
    rst_n = 1'b0;
    #1;
    check_output("midreset wren", int'(wren), 0);
    check_output("midreset busy", int'(busy), 0);
    check_output("midreset ready", int'(cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    wcount = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcount++;
      if (wren) wcount++;
    end
    check_output("midreset no done", dcount, 0);
    check_output("midreset no writes", wcount, 0);
    check_output("midreset ready after release", int'(cmd_ready), 1);
    apply_stimulus(vecs[0]);
    check_output("post-midreset writes", r_writes, 400);
    check_output("post-midreset first addr", r_first, 25820);
    check_output("post-midreset done cycle", r_done_at, 401);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imgmem_cell_writer.md
# imgmem_cell_writer

Write-side engine for the 8-bit palette-index image memory that the VGA path scans out at 640x480. It accepts draw commands over a valid/ready handshake and rasterises them into memory writes, one pixel per clock. A command either fills one Tetris board cell or clears the whole board rectangle. It sits between the game processor and the write port of the image memory, in the VGA clock domain.

## Interface
Parameters:
- CELL_SIZE, 20, cell edge in pixels.
- ORIGIN_X, 220, board left pixel column.
- ORIGIN_Y, 40, board top pixel row.
- GRID_COLS, 10, board width in cells.
- GRID_ROWS, 20, board height in cells.
- BORDER_INDEX, 8'd0, palette index for cell outline (used only with the border feature).

Ports:
- iVGA_CLK  in  1  sole clock, rising edge.
- iRST_n  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_clear  in  1  1 = clear board; 0 = fill one cell.
- cmd_col  in  4  cell column, 0..GRID_COLS-1.
- cmd_row  in  5  cell row, 0..GRID_ROWS-1.
- cmd_index  in  8  palette index to write.
- addr_imgmem_w  out  19  write address, y*640+x.
- data_imgmem_w  out  8  write data.
- wren_imgmem  out  1  write strobe, one pixel per asserted cycle.
- oBUSY  out  1  high in WRITE and DONE.
- oDONE  out  1  one-cycle pulse at command completion.
- oDROP  out  1  one-cycle pulse when an out-of-range cell command is discarded.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: cmd_ready=1. On cmd_valid, the command is accepted; all cmd_* fields are captured that cycle.
  - Cell command with cmd_col>=GRID_COLS or cmd_row>=GRID_ROWS: no writes, oDROP pulses the next cycle, stay in IDLE.
  - Any other command: go to WRITE.
- Cell rectangle: x0=ORIGIN_X+col*CELL_SIZE, y0=ORIGIN_Y+row*CELL_SIZE, size CELL_SIZE x CELL_SIZE.
- Clear rectangle: (ORIGIN_X, ORIGIN_Y), size GRID_COLS*CELL_SIZE x GRID_ROWS*CELL_SIZE.
- WRITE raster order: row-major, left to right, then top to bottom.
  - Pixel counter px and line counter py.
  - Address is incremental: +1 per pixel; at end of a line, +(640-width+1).
  - No per-pixel multiply. Base address is computed once at accept.
- wren_imgmem=1 on every WRITE cycle. data_imgmem_w is the captured index.
- After the last pixel, go to DONE: oDONE=1 for one cycle, cmd_ready=0. Then return to IDLE.
- Address arithmetic is 19-bit unsigned. The maximum address for the defaults (439*640+419) is below 2^19; no wrap-around handling.
- cmd_* inputs are ignored outside IDLE; cmd_valid held high while busy is not an accept.

## Timing
- Reset values: cmd_ready=0 while iRST_n=0 and 1 after release (IDLE). All other outputs 0: addr_imgmem_w, data_imgmem_w, wren_imgmem, oBUSY, oDONE, oDROP.
- Reset mid-command: the command is abandoned immediately. Pixels already written remain in memory; no further writes occur.
- Cell command accepted at cycle N:
  - first write at N+1, at address x0+y0*640;
  - last write at N+CELL_SIZE² (N+400 with defaults);
  - oDONE at N+CELL_SIZE²+1;
  - cmd_ready=1 at N+CELL_SIZE²+2.
- Clear command: same structure with 80000 writes (defaults); oDONE at N+80001.
- Dropped command at cycle N: oDROP at N+1, cmd_ready stays 1, so back-to-back accepts are possible.
- All outputs are registered.

## Configuration
- IMGMEM_WRITER_BORDER_EN defined: for cell commands, pixels with px==0, px==CELL_SIZE-1, py==0 or py==CELL_SIZE-1 are written with BORDER_INDEX; interior pixels use cmd_index. Clear commands never use the border. Write count and timing are unchanged.
- Undefined: every pixel uses cmd_index, and BORDER_INDEX is unused.

## Test plan
- Reset, then cell cmd col=0,row=0,index=8'h05 at cycle N -> 400 writes; first addr 25820 (40*640+220), last addr 25820+19*640+19=37999; oDONE at N+401; all data 8'h05.
- Cell col=9,row=19,index=8'h03 -> first addr (40+380)*640+(220+180)=269200; line step of 621 after each 20 pixels.
- Clear cmd index=0 -> exactly 80000 writes covering x 220..419 and y 40..439; no write outside that range; single oDONE pulse.
- Cell col=10,row=0 -> no wren, oDROP one cycle, cmd_ready stays 1; a valid command the next cycle is accepted.
- iRST_n low at write 200 of a cell -> wren_imgmem=0 immediately; after release cmd_ready=1, no oDONE, and a new command executes in full.
- With IMGMEM_WRITER_BORDER_EN, cell index 8'h07 -> 76 writes of BORDER_INDEX and 324 writes of 8'h07; without the macro, 400 writes of 8'h07.
